// File: rtl/ref_slew_limiter.sv
// Rate-limited reference setpoint: slews ref_out toward the latched target
// by at most STEP LSBs per prescaler tick, with a settled flag.
module ref_slew_limiter #(
    parameter int cant_bits = 13,
    parameter int STEP      = 8,
    parameter int DIV       = 50000,
    parameter int CNT_W     = 16
) (
    input  logic                        CLK_G,
    input  logic                        reset_G,
    input  logic signed [cant_bits-1:0] ref_in,
    input  logic                        ref_load,
    input  logic                        hold,
    output logic signed [cant_bits-1:0] ref_out,
    output logic                        ref_tick,
    output logic                        settled
);

    typedef enum logic {
        IDLE,
        RAMP
    } state_t;

    localparam logic signed [cant_bits-1:0] STEP_V = cant_bits'(STEP);
    localparam logic [cant_bits:0]          STEP_M = (cant_bits+1)'(STEP);
    localparam logic [CNT_W-1:0]            CNT_MAX = CNT_W'(DIV - 1);

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [cant_bits-1:0] target_q, target_d;
    logic signed [cant_bits-1:0] ref_out_q, ref_out_d;
    logic                        ref_tick_q, ref_tick_d;

    logic                        tick;
    logic signed [cant_bits:0]   diff;
    logic [cant_bits:0]          mag;

    always_comb begin
        tick       = (cnt_q == CNT_MAX);
        cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);
        ref_tick_d = tick;

        // One extra bit keeps full-scale differences from wrapping.
        diff = {target_q[cant_bits-1], target_q}
             - {ref_out_q[cant_bits-1], ref_out_q};
        mag  = diff[cant_bits] ? $unsigned(-diff) : $unsigned(diff);

        state_d   = state_q;
        target_d  = target_q;
        ref_out_d = ref_out_q;

        if (state_q == RAMP && tick && !hold) begin
            if (mag <= STEP_M) begin
                ref_out_d = target_q;
                state_d   = IDLE;
            end else if (!diff[cant_bits]) begin
                ref_out_d = ref_out_q + STEP_V;
            end else begin
                ref_out_d = ref_out_q - STEP_V;
            end
        end

        // A new target is compared against the value leaving this edge,
        // so a simultaneous step can never strand IDLE off target.
        if (ref_load) begin
            target_d = ref_in;
            state_d  = (ref_in != ref_out_d) ? RAMP : IDLE;
        end
    end

    always_ff @(posedge CLK_G or negedge reset_G) begin
        if (!reset_G) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            target_q   <= '0;
            ref_out_q  <= '0;
            ref_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            target_q   <= target_d;
            ref_out_q  <= ref_out_d;
            ref_tick_q <= ref_tick_d;
        end
    end

    assign ref_out  = ref_out_q;
    assign ref_tick = ref_tick_q;
    assign settled  = (state_q == IDLE) && (ref_out_q == target_q);

endmodule

// File: tb/tb_ref_slew_limiter.sv
// Scoreboard bench for ref_slew_limiter: directed scenarios plus random
// traffic checked against an integer reference model.
module tb_ref_slew_limiter;

    localparam int W    = 13;
    localparam int STEP = 8;
    localparam int DIV  = 4;

    logic                CLK_G = 1'b0;
    logic                reset_G;
    logic signed [W-1:0] ref_in;
    logic                ref_load;
    logic                hold;
    logic signed [W-1:0] ref_out;
    logic                ref_tick;
    logic                settled;

    ref_slew_limiter #(
        .cant_bits(W),
        .STEP(STEP),
        .DIV(DIV),
        .CNT_W(16)
    ) dut (
        .CLK_G(CLK_G),
        .reset_G(reset_G),
        .ref_in(ref_in),
        .ref_load(ref_load),
        .hold(hold),
        .ref_out(ref_out),
        .ref_tick(ref_tick),
        .settled(settled)
    );

    always #5 CLK_G = ~CLK_G;

    typedef struct {
        int    out;
        bit    tick;
        bit    settled;
        string tag;
    } exp_t;

    exp_t  q[$];
    event  async_ev;
    string phase = "init";
    int    checks = 0;
    int    errors = 0;

    // Model state: setpoint, target, ramping flag, edges since release.
    int m_out  = 0;
    int m_tgt  = 0;
    bit m_ramp = 0;
    int m_cyc  = 0;

    task automatic model_reset();
        m_out  = 0;
        m_tgt  = 0;
        m_ramp = 0;
        m_cyc  = 0;
    endtask

    task automatic push_exp(input bit tk);
        exp_t e;
        e.out     = m_out;
        e.tick    = tk;
        e.settled = !m_ramp && (m_out == m_tgt);
        e.tag     = phase;
        q.push_back(e);
    endtask

    // Predicts the outputs after the coming rising edge.
    task automatic model_step();
        bit tk;
        int nxt;
        int d;
        if (!reset_G) begin
            model_reset();
            push_exp(1'b0);
        end else begin
            tk  = (m_cyc % DIV) == DIV - 1;
            nxt = m_out;
            if (tk && m_ramp && !hold) begin
                d = m_tgt - m_out;
                if (d <= STEP && d >= -STEP) begin
                    nxt    = m_tgt;
                    m_ramp = 0;
                end else begin
                    nxt = (d > 0) ? m_out + STEP : m_out - STEP;
                end
            end
            if (ref_load) begin
                m_tgt  = int'(ref_in);
                m_ramp = (m_tgt != nxt);
            end
            m_out = nxt;
            m_cyc++;
            push_exp(tk);
        end
    endtask

    task automatic cyc(input logic r, input logic ld,
                       input int v, input logic h);
        @(negedge CLK_G);
        reset_G  = r;
        ref_load = ld;
        ref_in   = W'(v);
        hold     = h;
        model_step();
    endtask

    task automatic step();
        cyc(1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic timeout(input string what);
        $display("FAIL timeout %s: got no progress, required completion", what);
        $fatal(1, "bench stopped");
    endtask

    task automatic run_idle(input int bound);
        int n = 0;
        while (m_ramp) begin
            step();
            n++;
            if (n > bound) timeout(phase);
        end
    endtask

    task automatic load_settle(input int v, input int bound);
        cyc(1'b1, 1'b1, v, 1'b0);
        run_idle(bound);
        repeat (2) step();
    endtask

    task automatic wait_out(input int v, input bit on_tick, input int bound);
        int n = 0;
        while (!(m_out == v && (!on_tick || (m_cyc % DIV) == DIV - 1))) begin
            step();
            n++;
            if (n > bound) timeout(phase);
        end
    endtask

    task automatic async_reset();
        @(posedge CLK_G);
        #3;
        reset_G = 1'b0;
        model_reset();
        push_exp(1'b0);
        -> async_ev;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK_G or async_ev);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (ref_out !== W'(e.out) || ref_tick !== e.tick ||
                    settled !== e.settled) begin
                    errors++;
                    $display("FAIL %s: got out=%0d tick=%0b settled=%0b, want out=%0d tick=%0b settled=%0b",
                             e.tag, ref_out, ref_tick, settled,
                             e.out, e.tick, e.settled);
                end
            end
        end
    end

    initial begin : stim
        int v;
        reset_G  = 1'b1;
        ref_in   = '0;
        ref_load = 1'b0;
        hold     = 1'b0;
        #1 reset_G = 1'b0;

        phase = "reset";
        repeat (3) cyc(1'b0, 1'b0, 0, 1'b0);
        repeat (6) step();

        phase = "ramp_up_20";
        load_settle(20, 40);

        phase = "ramp_down_m20";
        load_settle(-20, 60);

        phase = "full_scale_up";
        load_settle(0, 40);
        load_settle(4095, 2200);

        phase = "full_scale_down";
        load_settle(-4096, 4300);

        phase = "hold";
        load_settle(0, 2200);
        cyc(1'b1, 1'b1, 20, 1'b0);
        wait_out(8, 1'b0, 20);
        repeat (12) cyc(1'b1, 1'b0, 0, 1'b1);
        run_idle(40);
        repeat (2) step();

        phase = "redirect";
        load_settle(0, 40);
        cyc(1'b1, 1'b1, 40, 1'b0);
        wait_out(16, 1'b1, 30);
        cyc(1'b1, 1'b1, 10, 1'b0);
        run_idle(40);
        repeat (2) step();

        phase = "async_reset";
        load_settle(0, 40);
        cyc(1'b1, 1'b1, 40, 1'b0);
        wait_out(16, 1'b0, 30);
        async_reset();
        repeat (2) cyc(1'b0, 1'b0, 0, 1'b0);
        repeat (10) step();

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 1)
                v = int'($urandom_range(0, 127)) - 64;
            else
                v = int'($urandom_range(0, 8191)) - 4096;
            cyc(1'b1, ($urandom_range(0, 23) == 0), v,
                ($urandom_range(0, 5) == 0));
        end

        @(posedge CLK_G);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ref_slew_limiter.md
Name: ref_slew_limiter

Overview:
Downstream stage of the switch-selected reference constant block. Accepts the signed reference constant (cant_bits wide) and a load strobe. Produces a rate-limited setpoint that moves toward the latest target by at most STEP LSBs per sample tick. Feeds the servo control loop, with a one-cycle sample strobe and a settled flag.

Parameters:
cant_bits, 13, width of the signed reference in/out; must match the constant memory width.
STEP, 8, maximum magnitude of change per tick; legal range 1 .. 2^(cant_bits-1)-1.
DIV, 50000, CLK_G cycles per sample tick; minimum 2.
CNT_W, 16, prescaler counter width; must satisfy 2^CNT_W >= DIV.

Ports:
CLK_G  in  1  single system clock; all state updates on the rising edge.
reset_G  in  1  asynchronous, active-low reset (0 = reset).
ref_in  in  cant_bits signed  target reference from the constant memory.
ref_load  in  1  when high on a clock edge, ref_in is latched as the new target.
hold  in  1  when high, freezes ref_out; the prescaler keeps running.
ref_out  out  cant_bits signed  rate-limited setpoint (registered).
ref_tick  out  1  one-cycle strobe, high in the cycle after each prescaler tick.
settled  out  1  high when ref_out == target and the FSM is in IDLE.

Behaviour:
- Reset (reset_G=0, asynchronous): target=0, ref_out=0, prescaler=0, state=IDLE, ref_tick=0, settled=1. Release is sampled on the next CLK_G edge.
- Prescaler: counts 0..DIV-1 and wraps. The internal tick is high in the cycle where count==DIV-1. The first tick after reset occurs DIV cycles after release.
- ref_tick: registered copy of the internal tick. It pulses on every tick, regardless of state or hold.
- Target: latched on any edge with ref_load=1.
  - If the new ref_in differs from ref_out, the state goes to RAMP on that edge and settled drops to 0 on the same edge.
  - If ref_in equals ref_out, the state stays or returns to IDLE.
- FSM states:
  - IDLE: ref_out is constant. Go to RAMP on ref_load with a differing value.
  - RAMP: on each tick with hold=0, compute diff = target - ref_out at cant_bits+1 bits, signed.
    - If |diff| <= STEP: ref_out = target, go to IDLE, settled = 1.
    - Else: ref_out = ref_out + STEP if diff > 0, otherwise ref_out - STEP. Stay in RAMP.
  - Tick with hold=1: no change to ref_out or state.
- Latency: ref_out changes on the same edge that ref_tick rises. Observers sampling on ref_tick=1 see the new value.
- Arithmetic: no overshoot and no overflow. The final step always clamps to target, and full-scale swings (-2^(cant_bits-1) to 2^(cant_bits-1)-1) must not wrap.
- ref_load and tick on the same edge: the step uses the old target; the new target is latched and used from the next tick.
- ref_load mid-ramp: the ramp redirects toward the new target from the current ref_out. There is no restart from 0.
- Reset mid-ramp: all registers return to their reset values immediately, without waiting for a clock edge.

Test Plan:
All bench cases use DIV=4, STEP=8, cant_bits=13.
1. Reset, then ref_load ref_in=20 -> settled falls next edge; ref_out goes 8, 16, 20 on successive ticks, 4 cycles apart; settled=1 with the third tick; ref_tick pulses every 4 cycles.
2. From 20, load -20 -> ref_out goes 12, 4, -4, -12, -20, then IDLE; no value beyond -20.
3. Full scale: load 4095 from 0 -> 511 ticks of +8 reach 4088, then the final step clamps to 4095; then load -4096 -> monotonic descent with no wrap, ending exactly at -4096.
4. Hold: during the 0->20 ramp at ref_out=8, hold=1 for 3 ticks -> ref_out stays 8 while ref_tick keeps pulsing; after release it goes 16, 20.
5. Redirect and simultaneity: at ref_out=16 (target 40), load 10 on a tick edge -> that tick gives 24; the next ticks give 16, then 10 (clamp), settled=1.
6. Async reset mid-ramp: pull reset_G low between clock edges at ref_out=16 -> ref_out=0, settled=1, ref_tick=0 immediately; after release, the first ref_tick comes 4 cycles later and ref_out stays 0.
